usb_rx_ll: RTL and testbench

Low-level full-speed USB receiver, the receive-direction counterpart of the low-level transmitter. It samples the raw D+/D- line at 48 MHz (4x the 12 Mbit/s bit rate) and recovers bit timing from line transitions. It decodes NRZI, removes stuffed bits, detects SYNC and EOP, and flags line errors. Its output is a per-bit stream with start, end and error strobes, which the packet-level receiver consumes to rebuild PID, payload and CRC.

---
 rtl/usb_rx_ll.sv | 159 +++++++++++++++
 tb/tb_usb_rx_ll.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_rx_ll.sv
// usb_rx_ll: full-speed USB low-level receiver. Recovers bit timing from 48 MHz line
// samples, decodes NRZI and bit stuffing, and frames packets between SYNC and EOP.
module usb_rx_ll #(
  parameter int unsigned MIN_SYNC_ZEROS = 5,
  parameter int unsigned SAMPLE_PHASE   = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic phy_rx_dp,
  input  logic phy_rx_dn,
  input  logic rx_en,
  output logic ll_start,
  output logic ll_bit,
  output logic ll_valid,
  output logic ll_eop,
  output logic ll_err,
  output logic ll_active
);
  typedef enum logic [2:0] {ST_IDLE, ST_SYNC, ST_DATA, ST_EOP1, ST_EOP2} state_t;

  localparam logic [1:0] LS_SE0 = 2'b00;
  localparam logic [1:0] LS_K   = 2'b01;
  localparam logic [1:0] LS_J   = 2'b10;
  localparam logic [1:0] LS_SE1 = 2'b11;

  state_t     state, state_n;
  logic [1:0] sync1, line, line_q;
  logic [1:0] ph_q, ph_cur;
  logic [1:0] prev_jk, prev_jk_n;
  logic [2:0] zcnt, zcnt_n, ones, ones_n;
  logic       strobe, is_jk, nrzi_bit;
  logic       start_n, valid_n, bit_n, eop_n, err_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= '0;
      line   <= '0;
      line_q <= '0;
    end else begin
      sync1  <= {phy_rx_dp, phy_rx_dn};
      line   <= sync1;
      line_q <= line;
    end
  end

  // Any change of line state realigns the recovered clock to phase 0.
  assign ph_cur   = (line != line_q) ? 2'd0 : ph_q;
  assign strobe   = (ph_cur == 2'(SAMPLE_PHASE));
  assign is_jk    = (line == LS_J) || (line == LS_K);
  assign nrzi_bit = (line == prev_jk);

  always_comb begin
    state_n   = state;
    zcnt_n    = zcnt;
    ones_n    = ones;
    prev_jk_n = prev_jk;
    start_n   = 1'b0;
    valid_n   = 1'b0;
    bit_n     = ll_bit;
    eop_n     = 1'b0;
    err_n     = 1'b0;
    if (strobe && is_jk) prev_jk_n = line;
    unique case (state)
      ST_IDLE: begin
        prev_jk_n = LS_J;
        if (strobe && line == LS_K) begin
          state_n   = ST_SYNC;
          zcnt_n    = 3'd1;
          prev_jk_n = LS_K;
        end
      end
      ST_SYNC: if (strobe) begin
        if (!is_jk) state_n = ST_IDLE;
        else if (!nrzi_bit) zcnt_n = (zcnt == 3'd7) ? zcnt : zcnt + 3'd1;
        else if (32'(zcnt) >= MIN_SYNC_ZEROS) begin
          start_n = 1'b1;
          state_n = ST_DATA;
          ones_n  = '0;
        end else state_n = ST_IDLE;
      end
      ST_DATA: if (strobe) begin
        case (line)
          LS_SE0: state_n = ST_EOP1;
          LS_SE1: begin
            err_n   = 1'b1;
            state_n = ST_IDLE;
          end
          default: begin
            if (ones == 3'd6) begin
              if (nrzi_bit) begin
                err_n   = 1'b1;
                state_n = ST_IDLE;
              end else ones_n = '0;
            end else begin
              valid_n = 1'b1;
              bit_n   = nrzi_bit;
              ones_n  = nrzi_bit ? ones + 3'd1 : '0;
            end
          end
        endcase
      end
      ST_EOP1: if (strobe) begin
        if (line == LS_SE0) state_n = ST_EOP2;
        else begin
          err_n   = 1'b1;
          state_n = ST_IDLE;
        end
      end
      ST_EOP2: if (strobe) begin
        if (line == LS_J) begin
          eop_n   = 1'b1;
          state_n = ST_IDLE;
        end else if (line != LS_SE0) begin
          err_n   = 1'b1;
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
    // Disabling mid-packet aborts once; only the states inside a packet report it.
    if (!rx_en) begin
      state_n   = ST_IDLE;
      prev_jk_n = LS_J;
      start_n   = 1'b0;
      valid_n   = 1'b0;
      eop_n     = 1'b0;
      err_n     = (state == ST_DATA) || (state == ST_EOP1) || (state == ST_EOP2);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      ph_q      <= '0;
      zcnt      <= '0;
      ones      <= '0;
      prev_jk   <= LS_J;
      ll_start  <= 1'b0;
      ll_bit    <= 1'b0;
      ll_valid  <= 1'b0;
      ll_eop    <= 1'b0;
      ll_err    <= 1'b0;
      ll_active <= 1'b0;
    end else begin
      state     <= state_n;
      ph_q      <= ph_cur + 2'd1;
      zcnt      <= zcnt_n;
      ones      <= ones_n;
      prev_jk   <= prev_jk_n;
      ll_start  <= start_n;
      ll_bit    <= bit_n;
      ll_valid  <= valid_n;
      ll_eop    <= eop_n;
      ll_err    <= err_n;
      // Stays high through the eop/err cycle, falls on the next one.
      ll_active <= start_n | (ll_active & ~(ll_eop | ll_err));
    end
  end
endmodule

// File: tb/tb_usb_rx_ll.sv
// Self-checking bench for usb_rx_ll: symbol-level packet model plus directed scenarios.
`timescale 1ns/1ps
module tb_usb_rx_ll;
  localparam logic [1:0] SE0 = 2'b00;
  localparam logic [1:0] K   = 2'b01;
  localparam logic [1:0] J   = 2'b10;
  localparam logic [1:0] SE1 = 2'b11;
  localparam int EV_START = 2;
  localparam int EV_EOP   = 3;
  localparam int EV_ERR   = 4;
  localparam int MINZ     = 5;

  logic clk = 1'b0;
  logic rst_n, phy_rx_dp, phy_rx_dn, rx_en;
  logic ll_start, ll_bit, ll_valid, ll_eop, ll_err, ll_active;

  usb_rx_ll #(.MIN_SYNC_ZEROS(MINZ), .SAMPLE_PHASE(2)) dut (
    .clk(clk), .rst_n(rst_n), .phy_rx_dp(phy_rx_dp), .phy_rx_dn(phy_rx_dn),
    .rx_en(rx_en), .ll_start(ll_start), .ll_bit(ll_bit), .ll_valid(ll_valid),
    .ll_eop(ll_eop), .ll_err(ll_err), .ll_active(ll_active)
  );

  always #10 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  int exp_q[$];
  int rec[$];
  int obs_bits[$];
  int obs_start = 0, obs_eop = 0, obs_err = 0;
  bit chk_mode = 1'b0, exp_act = 1'b0, clr_act = 1'b0;
  int cyc = 0, last_valid = -100;
  logic [1:0] pkt[$];
  logic [1:0] cur;
  int ones;

  task automatic chk(input string name, input int act, input int exp_v);
    n_chk++;
    if (act == exp_v) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
  endtask

  // Packet-level model: walks the per-bit symbol list and lists the strobes it must produce.
  function automatic void model(input logic [1:0] s[$], output int ev[$]);
    int i, zeros, ones_m;
    logic [1:0] prv, c;
    bit b, done;
    ev.delete();
    i = 0;
    while (i < s.size()) begin
      if (s[i] != K) begin i++; continue; end
      prv = K; zeros = 1; i++;
      while (i < s.size() && (s[i] == J || s[i] == K) && s[i] != prv) begin
        zeros = (zeros < 7) ? zeros + 1 : 7;
        prv = s[i]; i++;
      end
      if (i >= s.size()) break;
      if (!(s[i] == J || s[i] == K) || zeros < MINZ) begin i++; continue; end
      ev.push_back(EV_START);
      prv = s[i]; i++; ones_m = 0; done = 1'b0;
      while (!done && i < s.size()) begin
        c = s[i]; i++;
        if (c == SE1) begin ev.push_back(EV_ERR); done = 1'b1; end
        else if (c == SE0) begin
          done = 1'b1;
          if (i < s.size()) begin
            if (s[i] != SE0) begin ev.push_back(EV_ERR); i++; end
            else begin
              i++;
              while (i < s.size() && s[i] == SE0) i++;
              if (i < s.size()) begin ev.push_back(s[i] == J ? EV_EOP : EV_ERR); i++; end
            end
          end
        end else begin
          b = (c == prv); prv = c;
          if (ones_m == 6) begin
            if (b) begin ev.push_back(EV_ERR); done = 1'b1; end
            else ones_m = 0;
          end else begin
            ev.push_back(int'(b));
            ones_m = b ? ones_m + 1 : 0;
          end
        end
      end
    end
  endfunction

  task automatic take_event(input int e);
    int x;
    if (chk_mode) begin
      x = 99;
      if (exp_q.size() > 0) x = exp_q.pop_front();
      if (x == EV_START) exp_act = 1'b1;
      if (x == EV_EOP || x == EV_ERR) clr_act = 1'b1;
      chk("event_seq", e, x);
    end else rec.push_back(e);
  endtask

  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      clr_act = 1'b0;
      if (ll_start || ll_valid || ll_eop || ll_err) begin
        chk("start_valid_excl", int'(ll_start & ll_valid), 0);
        chk("eop_err_excl", int'(ll_eop & ll_err), 0);
      end
      if (ll_start) begin obs_start++; take_event(EV_START); end
      if (ll_valid) begin
        chk("valid_spacing_ge3", int'(cyc - last_valid >= 3), 1);
        last_valid = cyc;
        obs_bits.push_back(int'(ll_bit));
        take_event(int'(ll_bit));
      end
      if (ll_eop) begin obs_eop++; take_event(EV_EOP); end
      if (ll_err) begin obs_err++; take_event(EV_ERR); end
      if (chk_mode) chk("ll_active", int'(ll_active), int'(exp_act));
      if (clr_act) exp_act = 1'b0;
    end
  end

  task automatic add_n(input logic [1:0] s, input int n);
    repeat (n) pkt.push_back(s);
  endtask

  task automatic add_sync();
    pkt.push_back(K); pkt.push_back(J); pkt.push_back(K); pkt.push_back(J);
    pkt.push_back(K); pkt.push_back(J); pkt.push_back(K); pkt.push_back(K);
    cur = K; ones = 0;
  endtask

  task automatic add_byte(input logic [7:0] b, input bit stuff);
    for (int i = 0; i < 8; i++) begin
      if (!b[i]) cur = (cur == K) ? J : K;
      pkt.push_back(cur);
      ones = b[i] ? ones + 1 : 0;
      if (stuff && ones == 6) begin
        cur = (cur == K) ? J : K;
        pkt.push_back(cur);
        ones = 0;
      end
    end
  endtask

  task automatic build_ack();
    pkt.delete(); add_n(J, 4); add_sync(); add_byte(8'hD2, 1'b1); add_n(SE0, 2); add_n(J, 4);
  endtask

  // Drives one symbol per bit; with jit, runs of equal symbols get lengths 4n-1/4n+1/4n.
  task automatic play(input logic [1:0] s[$], input bit jit);
    int i, n, len, d;
    int dv[3];
    dv[0] = -1; dv[1] = 1; dv[2] = 0; i = 0; d = 0;
    while (i < s.size()) begin
      n = 1;
      while (i + n < s.size() && s[i+n] == s[i]) n++;
      len = 4 * n + (jit ? dv[d] : 0);
      d = (d + 1) % 3;
      {phy_rx_dp, phy_rx_dn} = s[i];
      repeat (len) @(negedge clk);
      i += n;
    end
  endtask

  task automatic run_checked(input bit jit);
    model(pkt, exp_q);
    obs_bits.delete(); obs_start = 0; obs_eop = 0; obs_err = 0;
    exp_act = 1'b0; chk_mode = 1'b1;
    play(pkt, jit);
    for (int t = 0; t < 100 && exp_q.size() > 0; t++) @(negedge clk);
    chk("expected_events_drained", exp_q.size(), 0);
    repeat (8) @(negedge clk);
    chk_mode = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int ev[$];
    int lit[$];
    int ack_bits[$];
    logic [1:0] pre[$], rest[$];
    int n;

    rst_n = 1'b0; rx_en = 1'b1; {phy_rx_dp, phy_rx_dn} = J;
    repeat (3) @(negedge clk);
    chk("reset_start", int'(ll_start), 0);
    chk("reset_valid", int'(ll_valid), 0);
    chk("reset_bit", int'(ll_bit), 0);
    chk("reset_eop", int'(ll_eop), 0);
    chk("reset_err", int'(ll_err), 0);
    chk("reset_active", int'(ll_active), 0);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);

    ack_bits = '{0, 1, 0, 0, 1, 0, 1, 1};

    build_ack();
    model(pkt, ev);
    lit = '{2, 0, 1, 0, 0, 1, 0, 1, 1, 3};
    chk("model_ack_len", ev.size(), lit.size());
    foreach (lit[i]) chk("model_ack_ev", (ev.size() > i) ? ev[i] : -1, lit[i]);
    run_checked(1'b0);
    chk("ack_starts", obs_start, 1);
    chk("ack_eops", obs_eop, 1);
    chk("ack_errs", obs_err, 0);
    chk("ack_nbits", obs_bits.size(), 8);
    foreach (ack_bits[i]) chk("ack_bit", (obs_bits.size() > i) ? obs_bits[i] : -1, ack_bits[i]);

    pkt.delete(); add_n(J, 4); add_sync(); add_byte(8'hC3, 1'b1); add_byte(8'hFF, 1'b1);
    add_n(SE0, 2); add_n(J, 4);
    run_checked(1'b0);
    chk("stuff_nbits", obs_bits.size(), 16);
    lit = '{1, 1, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
    foreach (lit[i]) chk("stuff_bit", (obs_bits.size() > i) ? obs_bits[i] : -1, lit[i]);
    chk("stuff_eops", obs_eop, 1);
    chk("stuff_errs", obs_err, 0);

    pkt.delete(); add_n(J, 4); add_sync(); add_n(K, 7); add_n(J, 4);
    model(pkt, ev);
    lit = '{2, 1, 1, 1, 1, 1, 1, 4};
    chk("model_stufferr_len", ev.size(), lit.size());
    foreach (lit[i]) chk("model_stufferr_ev", (ev.size() > i) ? ev[i] : -1, lit[i]);
    run_checked(1'b0);
    chk("stufferr_nbits", obs_bits.size(), 6);
    chk("stufferr_errs", obs_err, 1);
    chk("stufferr_eops", obs_eop, 0);
    chk("stufferr_active_low", int'(ll_active), 0);

    build_ack();
    run_checked(1'b1);
    chk("jitter_nbits", obs_bits.size(), 8);
    foreach (ack_bits[i]) chk("jitter_bit", (obs_bits.size() > i) ? obs_bits[i] : -1, ack_bits[i]);
    chk("jitter_eops", obs_eop, 1);
    chk("jitter_errs", obs_err, 0);

    pkt.delete(); add_n(J, 4); add_n(K, 1); add_n(J, 1); add_n(K, 2); add_n(J, 4);
    run_checked(1'b0);
    chk("short_sync_starts", obs_start, 0);
    chk("short_sync_nbits", obs_bits.size(), 0);

    pkt.delete(); add_n(J, 4); add_sync(); add_byte(8'hD2, 1'b1); add_n(SE0, 1); add_n(K, 1);
    add_n(J, 4);
    run_checked(1'b0);
    chk("bad_eop_errs", obs_err, 1);
    chk("bad_eop_eops", obs_eop, 0);
    chk("bad_eop_nbits", obs_bits.size(), 8);

    build_ack();
    pre = pkt[0:15];
    rest = pkt[16:$];
    model(pre, ev);
    rec.delete(); obs_eop = 0; obs_err = 0;
    play(pre, 1'b0);
    chk("rxen_active_before", int'(ll_active), 1);
    rx_en = 1'b0;
    play(rest, 1'b0);
    repeat (8) @(negedge clk);
    rx_en = 1'b1;
    repeat (8) @(negedge clk);
    chk("rxen_rec_len_ok", int'(rec.size() >= 3 && rec.size() <= 6), 1);
    chk("rxen_first_start", (rec.size() > 0) ? rec[0] : -1, EV_START);
    chk("rxen_last_err", (rec.size() > 0) ? rec[rec.size()-1] : -1, EV_ERR);
    for (int i = 1; i < rec.size() - 1; i++) chk("rxen_bit", rec[i], (ev.size() > i) ? ev[i] : 99);
    chk("rxen_errs", obs_err, 1);
    chk("rxen_eops", obs_eop, 0);
    chk("rxen_active_after", int'(ll_active), 0);

    build_ack();
    pre = pkt[0:15];
    rec.delete();
    play(pre, 1'b0);
    chk("rst_active_before", int'(ll_active), 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_start", int'(ll_start), 0);
    chk("rst_mid_valid", int'(ll_valid), 0);
    chk("rst_mid_bit", int'(ll_bit), 0);
    chk("rst_mid_eop", int'(ll_eop), 0);
    chk("rst_mid_err", int'(ll_err), 0);
    chk("rst_mid_active", int'(ll_active), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    n = 0;
    foreach (rec[i]) if (rec[i] == EV_ERR) n++;
    chk("rst_no_err", n, 0);

    build_ack();
    run_checked(1'b0);
    chk("post_rst_starts", obs_start, 1);
    chk("post_rst_nbits", obs_bits.size(), 8);
    foreach (ack_bits[i]) chk("post_rst_bit", (obs_bits.size() > i) ? obs_bits[i] : -1, ack_bits[i]);
    chk("post_rst_eops", obs_eop, 1);
    chk("post_rst_errs", obs_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
